// File: rtl/screen_mux.sv
// Display multiplexer for a clock/alarm screen: shows a selected time source in
// normal mode and the configure value, with a blinking field, in configure mode.
module screen_mux #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_FIELD  = 3,
  parameter int FIELD_W    = 8,
  parameter int BLINK_HALF = 4,
  localparam int W  = NUM_FIELD * FIELD_W,
  localparam int FW = (NUM_FIELD > 1) ? $clog2(NUM_FIELD) : 1,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [1:0]             conf_stat,
  input  logic                   conf_pulse,
  input  logic [FW-1:0]          conf_field,
  input  logic [SW-1:0]          src_sel,
  input  logic [NUM_SRC*W-1:0]   src_time,
  input  logic [W-1:0]           conf_time,
  output logic [W-1:0]           screen_time,
  output logic [NUM_FIELD-1:0]   blank_mask,
  output logic                   screen_valid
);

  typedef enum logic [1:0] {
    S_SHOW,
    S_EDIT,
    S_EXIT
  } state_t;

  state_t               r_state;
  logic [W-1:0]         r_time;
  logic [NUM_FIELD-1:0] r_blank;
  logic                 r_valid;
  logic [7:0]           r_cnt;
  logic                 r_phase;
  logic                 r_pulse_d;

  state_t               w_state_nxt;
  logic [W-1:0]         w_time_nxt;
  logic [NUM_FIELD-1:0] w_blank_nxt;
  logic                 w_load;
  logic [7:0]           w_cnt_nxt;
  logic                 w_phase_nxt;
  logic                 w_rise;
  logic                 w_conf;
  logic [SW-1:0]        w_src_idx;
  logic [W-1:0]         w_src;
  logic [NUM_FIELD-1:0] w_onehot;

  // Out-of-range selects fall back to source 0; out-of-range fields blank nothing.
  always_comb begin
    w_rise    = conf_pulse & ~r_pulse_d;
    w_conf    = (conf_stat != 2'd0);
    w_src_idx = (int'(src_sel) < NUM_SRC) ? src_sel : '0;
    w_src     = src_time[int'(w_src_idx)*W +: W];
    w_onehot  = '0;
    for (int i = 0; i < NUM_FIELD; i++) begin
      w_onehot[i] = (int'(conf_field) == i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_blank_nxt = r_blank;
    w_load      = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    case (r_state)
      S_SHOW: begin
        if (w_conf) begin
          w_state_nxt = S_EDIT;
          w_time_nxt  = conf_time;
          w_load      = 1'b1;
          w_cnt_nxt   = 8'd0;
          w_phase_nxt = 1'b1;
          w_blank_nxt = '0;
        end else if (tick) begin
          w_time_nxt = w_src;
          w_load     = 1'b1;
        end
      end
      S_EDIT: begin
        if (!w_conf) begin
          w_state_nxt = S_EXIT;
          w_blank_nxt = '0;
        end else begin
          if (w_rise) begin
            w_time_nxt = conf_time;
            w_load     = 1'b1;
          end
          if (tick) begin
            if (r_cnt == 8'(BLINK_HALF - 1)) begin
              w_cnt_nxt   = 8'd0;
              w_phase_nxt = ~r_phase;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
          // Mask follows the phase being written so it never lags the blink toggle.
          w_blank_nxt = w_phase_nxt ? '0 : w_onehot;
        end
      end
      S_EXIT: begin
        w_time_nxt = w_src;
        w_load     = 1'b1;
        if (w_conf) begin
          w_state_nxt = S_EDIT;
          w_cnt_nxt   = 8'd0;
          w_phase_nxt = 1'b1;
          w_blank_nxt = '0;
        end else begin
          w_state_nxt = S_SHOW;
        end
      end
      default: w_state_nxt = S_SHOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_SHOW;
      r_time    <= '0;
      r_blank   <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= 8'd0;
      r_phase   <= 1'b1;
      r_pulse_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_time    <= w_time_nxt;
      r_blank   <= w_blank_nxt;
      r_valid   <= w_load;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_pulse_d <= conf_pulse;
    end
  end

  assign screen_time  = r_time;
  assign blank_mask   = r_blank;
  assign screen_valid = r_valid;

endmodule

// File: doc/screen_mux.md
SCREEN_MUX -- requirements
Module: screen_mux

Interface
REQ-001 Parameter NUM_SRC, default 2, number of selectable time sources (clock, alarm, ...).
REQ-002 Parameter NUM_FIELD, default 3, fields per time word (hour, minute, second), MSB field first.
REQ-003 Parameter FIELD_W, default 8, bits per field; W = NUM_FIELD*FIELD_W.
REQ-004 Parameter BLINK_HALF, default 4, ticks per blink half-period, legal range 1..255.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 tick  in  1  refresh strobe, one clk cycle wide.
REQ-008 conf_stat  in  2  0 = normal display; any nonzero value = configure mode.
REQ-009 conf_pulse  in  1  level from the configure logic; each rising edge = new conf_time value.
REQ-010 conf_field  in  clog2(NUM_FIELD)  index of the field being edited (0 = MSB field).
REQ-011 src_sel  in  clog2(NUM_SRC)  selects the displayed source in normal mode.
REQ-012 src_time  in  NUM_SRC*W  packed sources; source k occupies bits [k*W +: W].
REQ-013 conf_time  in  W  value being configured.
REQ-014 screen_time  out  W  registered display word.
REQ-015 blank_mask  out  NUM_FIELD  bit i = 1 means field i is dark; bit i maps to screen_time field i.
REQ-016 screen_valid  out  1  one-cycle strobe, high in the cycle screen_time takes a new load.

Function
REQ-017 The FSM SHALL have states SHOW, EDIT and EXIT; all outputs registered, no combinational input-to-output path.
REQ-018 conf_pulse SHALL be registered once (pulse_d); rise = conf_pulse & ~pulse_d; input is assumed synchronous to clk.
REQ-019 SHOW, conf_stat==0, tick=1: screen_time <= source src_sel; src_sel >= NUM_SRC selects source 0.
REQ-020 SHOW, conf_stat!=0: go EDIT; same edge load conf_time, clear blink counter, blink phase = on; this overrides a simultaneous tick.
REQ-021 EDIT: each rise SHALL load conf_time; level-held conf_pulse SHALL NOT reload.
REQ-022 EDIT: each tick increments the blink counter; on reaching BLINK_HALF-1 it wraps to 0 and toggles phase.
REQ-023 EDIT: blank_mask = one-hot(conf_field) while phase off, else 0; conf_field >= NUM_FIELD gives 0.
REQ-024 EDIT, conf_stat==0: go EXIT; blank_mask <= 0 on that edge.
REQ-025 EXIT: unconditionally load the selected source, then go SHOW; if conf_stat!=0 again, go EDIT instead.
REQ-026 Rise and tick in the same EDIT cycle: conf_time loads and the blink counter still advances.
REQ-027 screen_valid SHALL be 1 exactly in the cycle after any load edge; two loads in consecutive cycles give 2 high cycles.
REQ-028 screen_time SHALL otherwise hold; no truncation or arithmetic is applied to field values.

Reset
REQ-029 rst=1 SHALL immediately force: screen_time=0, blank_mask=0, screen_valid=0, state SHOW, blink counter 0, phase on, pulse_d=0.
REQ-030 Reset asserted mid-EDIT SHALL abandon the edit; after release the first load occurs on the next tick.

Verification
REQ-031 Defaults; src_time = {24'h0A1E00, 24'h123456}, src_sel=0, tick -> screen_time=24'h123456, screen_valid one cycle; src_sel=1, tick -> 24'h0A1E00.
REQ-032 conf_stat=1, conf_time=24'h070000 -> next edge screen_time=24'h070000, state EDIT; conf_time=24'h080000 with rise -> 24'h080000; level held 10 cycles -> no further valid.
REQ-033 EDIT, conf_field=1, 16 ticks -> blank_mask toggles 3'b000 / 3'b010 every 4 ticks, starting at 3'b000.
REQ-034 EDIT -> conf_stat=0 with no tick -> blank_mask=0, then screen_time = selected source within 2 cycles, one valid strobe.
REQ-035 SHOW, conf_stat 0->2 and tick in the same cycle -> conf_time loaded, not src_time; src_sel=3 with NUM_SRC=2 -> source 0 shown.
REQ-036 rst asserted mid-EDIT with blank_mask=3'b100 -> all outputs zero immediately; after release, no load until first tick.
